list_cmd_ctrl: RTL and testbench
================================

Name: list_cmd_ctrl

Overview:
- Upstream command front-end for the list storage block.
- Accepts list commands over a valid/ready channel and issues each one as a single-cycle op_en pulse with op_sel/data_in/index_in.
- Waits for the list's op_done, then returns the result and status over a valid/ready response channel.
- Guarantees one outstanding operation at a time, range-checks indices locally, and respects the list's one-cycle post-access recovery.

Parameters:
- DATA_WIDTH, 32, width of list data words.
- LENGTH, 8, number of list entries; used for index range check.
- TIMEOUT_CYCLES, 64, WAIT-state cycle limit; used only when LIST_CMD_TIMEOUT_EN is defined.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  3  0 read, 1 write, 2 find_all_index, 3 find_1st_index, 4 sum, 5 sort_asc, 6 sort_des.
- cmd_data  in  DATA_WIDTH  write data / search key.
- cmd_index  in  $clog2(LENGTH+1)  entry index.
- op_sel  out  3  to list.
- op_en  out  1  to list; one-cycle pulse per command.
- data_in  out  DATA_WIDTH  to list.
- index_in  out  $clog2(LENGTH+1)  to list.
- data_out  in  $clog2(LENGTH+1)+DATA_WIDTH  result from list.
- op_done  in  1  from list.
- op_error  in  1  from list.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  $clog2(LENGTH+1)+DATA_WIDTH  captured list result.
- rsp_error  out  1  list error, local range/opcode error, or timeout.
- rsp_timeout  out  1  response was produced by timeout.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - cmd_ready=0 while rst low, then 1 in IDLE.
  - op_en=0; op_sel, data_in, index_in = 0.
  - rsp_valid=0; rsp_data=0; rsp_error=0; rsp_timeout=0.
- State machine: IDLE, ISSUE, WAIT, RESP.
  - IDLE:
    - cmd_ready=1.
    - On cmd_valid&cmd_ready: register op/data/index.
    - If cmd_op==7, or cmd_op in {0,1} with cmd_index>=LENGTH: go to RESP with rsp_error=1 and rsp_data=0. No op_en is issued.
    - Otherwise go to ISSUE.
  - ISSUE:
    - Exactly one cycle; op_en=1 with registered op_sel/data_in/index_in.
    - Next state is WAIT.
    - op_done is ignored in IDLE and ISSUE, including the list's reset value of 1.
  - WAIT:
    - op_en=0.
    - On op_done=1: capture data_out into rsp_data and op_error into rsp_error, then go to RESP.
    - Single-cycle ops therefore see op_done on the first WAIT cycle.
  - RESP:
    - rsp_valid=1; rsp_data, rsp_error and rsp_timeout are held stable until rsp_ready.
    - On rsp_valid&rsp_ready: go to IDLE.
- Latency:
  - Accept edge T; op_en high during cycle T+1; rsp_valid high from cycle T+3 for single-cycle ops.
  - Minimum spacing between op_en pulses is 4 cycles, which covers the list's ACCESS_DONE recovery cycle.
- Backpressure: rsp_ready held low stalls in RESP indefinitely; cmd_ready stays 0.
- cmd_valid while not in IDLE is ignored (cmd_ready=0). No command is dropped; it stays pending upstream.
- Command fields are registered at acceptance. Upstream changes after the handshake have no effect.
- Reset mid-operation: the in-flight command is discarded, no response is produced, and op_en drops immediately.

Optional Feature:
- Macro: LIST_CMD_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES with op_done still low: go to RESP with rsp_error=1, rsp_timeout=1, rsp_data=0.
  - If op_done and the limit occur in the same cycle, op_done wins.
- Not defined: WAIT has no limit, the counter is absent, and rsp_timeout is tied 0.

Decomposition:
- Shared package list_pkg holds:
  - Opcode localparams (OP_READ=3'd0 … OP_SORT_DES=3'd6).
  - Controller state encoding (2 bits).
  - A function computing result width $clog2(LENGTH+1)+DATA_WIDTH.
- One sub-module: list_cmd_timeout, a counter with clear/enable/expired outputs, instantiated only under LIST_CMD_TIMEOUT_EN.

Test Plan (DATA_WIDTH=32, LENGTH=8):
- Write op=1, index=3, data=32'hDEADBEEF; then read index=3.
  - op_en is a single pulse per command.
  - Read response: rsp_data=32'hDEADBEEF, rsp_error=0; rsp_valid at T+3.
- Read index=8 (out of range).
  - No op_en pulse.
  - Response: rsp_error=1, rsp_data=0 on the cycle after acceptance.
- Opcode 7.
  - No op_en; rsp_error=1.
  - A follow-up read at index 0 completes normally.
- Hold rsp_ready=0 for 10 cycles after a read.
  - rsp_valid and rsp_data stay stable; cmd_ready=0 throughout.
  - A second cmd_valid is not accepted until the response is taken.
- Deassert rst during WAIT.
  - rsp_valid=0 and op_en=0 immediately.
  - After release, cmd_ready=1 and no stale response appears.
- With LIST_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=4: stub holds op_done=0.
  - Response after 4 WAIT cycles with rsp_error=1, rsp_timeout=1.
  - Without the macro, the controller stays in WAIT for 100 cycles.

Source files
------------

// File: rtl/list_pkg.sv
// Shared definitions for the list command front-end: opcodes, controller
// state encoding and the width of a list result word.
package list_pkg;

    localparam logic [2:0] OP_READ      = 3'd0;
    localparam logic [2:0] OP_WRITE     = 3'd1;
    localparam logic [2:0] OP_FIND_ALL  = 3'd2;
    localparam logic [2:0] OP_FIND_1ST  = 3'd3;
    localparam logic [2:0] OP_SUM       = 3'd4;
    localparam logic [2:0] OP_SORT_ASC  = 3'd5;
    localparam logic [2:0] OP_SORT_DES  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } ctrl_state_t;

    function automatic int result_width(input int length, input int data_width);
        return $clog2(length + 1) + data_width;
    endfunction

    function automatic logic op_known(input logic [2:0] op);
        case (op)
            OP_READ, OP_WRITE, OP_FIND_ALL, OP_FIND_1ST,
            OP_SUM, OP_SORT_ASC, OP_SORT_DES: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    // Only single-entry accesses carry an index the list will dereference.
    function automatic logic op_needs_index(input logic [2:0] op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

endpackage

// File: rtl/list_cmd_timeout.sv
// WAIT-state watchdog: counts enabled cycles since clear and flags the cycle on
// which the count reaches LIMIT. Instantiated only under LIST_CMD_TIMEOUT_EN.
module list_cmd_timeout #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            CW   = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
    localparam logic [CW-1:0] MAX  = CW'(LIMIT);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != MAX)) begin
            count <= count + CW'(1);
        end
    end

    // Fires during the WAIT cycle whose increment brings the count to LIMIT.
    assign expired = enable && (count == LAST);

endmodule

// File: rtl/list_cmd_ctrl.sv
// Command front-end for the list block: one outstanding op, local range check,
// response hand-back. Optional WAIT watchdog under LIST_CMD_TIMEOUT_EN.
module list_cmd_ctrl
    import list_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int LENGTH         = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         cmd_valid,
    output logic                                         cmd_ready,
    input  logic [2:0]                                   cmd_op,
    input  logic [DATA_WIDTH-1:0]                        cmd_data,
    input  logic [$clog2(LENGTH+1)-1:0]                  cmd_index,
    output logic [2:0]                                   op_sel,
    output logic                                         op_en,
    output logic [DATA_WIDTH-1:0]                        data_in,
    output logic [$clog2(LENGTH+1)-1:0]                  index_in,
    input  logic [result_width(LENGTH, DATA_WIDTH)-1:0]  data_out,
    input  logic                                         op_done,
    input  logic                                         op_error,
    output logic                                         rsp_valid,
    input  logic                                         rsp_ready,
    output logic [result_width(LENGTH, DATA_WIDTH)-1:0]  rsp_data,
    output logic                                         rsp_error,
    output logic                                         rsp_timeout
);

    localparam int            IW          = $clog2(LENGTH + 1);
    localparam int            RW          = result_width(LENGTH, DATA_WIDTH);
    localparam logic [IW-1:0] INDEX_LIMIT = IW'(LENGTH);

    ctrl_state_t state, state_next;

    logic [2:0]            op_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [IW-1:0]         index_q;
    logic [RW-1:0]         rsp_data_q;
    logic                  rsp_error_q;

    logic cmd_bad;
    logic load_cmd;
    logic cap_list;
    logic cap_local;
    logic cap_timeout;
    logic timeout_hit;

    assign cmd_bad = !op_known(cmd_op) || (op_needs_index(cmd_op) && (cmd_index >= INDEX_LIMIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can infer a latch.
        state_next  = state;
        cmd_ready   = 1'b0;
        op_en       = 1'b0;
        rsp_valid   = 1'b0;
        load_cmd    = 1'b0;
        cap_list    = 1'b0;
        cap_local   = 1'b0;
        cap_timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                // Reset forces IDLE asynchronously, so gate ready with rst to keep it low while held.
                cmd_ready = rst;
                if (cmd_valid && rst) begin
                    load_cmd = 1'b1;
                    if (cmd_bad) begin
                        cap_local  = 1'b1;
                        state_next = ST_RESP;
                    end else begin
                        state_next = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                op_en      = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (op_done) begin
                    cap_list   = 1'b1;
                    state_next = ST_RESP;
                end else if (timeout_hit) begin
                    cap_timeout = 1'b1;
                    state_next  = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q        <= '0;
            data_q      <= '0;
            index_q     <= '0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            if (load_cmd) begin
                op_q    <= cmd_op;
                data_q  <= cmd_data;
                index_q <= cmd_index;
            end
            if (cap_list) begin
                rsp_data_q  <= data_out;
                rsp_error_q <= op_error;
            end else if (cap_local || cap_timeout) begin
                rsp_data_q  <= '0;
                rsp_error_q <= 1'b1;
            end
        end
    end

    assign op_sel    = op_q;
    assign data_in   = data_q;
    assign index_in  = index_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_error = rsp_error_q;

`ifdef LIST_CMD_TIMEOUT_EN
    logic rsp_timeout_q;

    list_cmd_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == ST_ISSUE),
        .enable  (state == ST_WAIT),
        .expired (timeout_hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        rsp_timeout_q <= 1'b0;
        else if (cap_list || cap_local)  rsp_timeout_q <= 1'b0;
        else if (cap_timeout)            rsp_timeout_q <= 1'b1;
    end

    assign rsp_timeout = rsp_timeout_q;
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign rsp_timeout        = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_list_cmd_ctrl.sv
// Scoreboard bench for list_cmd_ctrl with a behavioural list stub. The timeout
// scenario follows LIST_CMD_TIMEOUT_EN the same way the design does.
`timescale 1ns/1ps
module tb_list_cmd_ctrl;

    localparam int DW  = 32;
    localparam int LEN = 8;
    localparam int IW  = $clog2(LEN + 1);
    localparam int RW  = IW + DW;
    localparam int TMO = 4;

    typedef struct packed {
        logic [RW-1:0] data;
        logic          err;
        logic          tmo;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [DW-1:0] cmd_data;
    logic [IW-1:0] cmd_index;
    logic [2:0]    op_sel;
    logic          op_en;
    logic [DW-1:0] data_in;
    logic [IW-1:0] index_in;
    logic [RW-1:0] data_out;
    logic          op_done;
    logic          op_error;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [RW-1:0] rsp_data;
    logic          rsp_error;
    logic          rsp_timeout;

    int checks = 0;
    int errors = 0;

    rsp_t          exp_q[$];
    logic [DW-1:0] ref_mem [LEN];
    logic [DW-1:0] stub_mem [LEN];
    logic          stub_hang = 1'b0;

    int ncyc      = 0;
    int op_en_cnt = 0;
    int last_en   = 0;
    int last_gap  = 0;

    always #5 clk = ~clk;

    list_cmd_ctrl #(
        .DATA_WIDTH     (DW),
        .LENGTH         (LEN),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_data    (cmd_data),
        .cmd_index   (cmd_index),
        .op_sel      (op_sel),
        .op_en       (op_en),
        .data_in     (data_in),
        .index_in    (index_in),
        .data_out    (data_out),
        .op_done     (op_done),
        .op_error    (op_error),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_error   (rsp_error),
        .rsp_timeout (rsp_timeout)
    );

    // List stub: op_done resets to 1 and answers one cycle after op_en unless hung.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_done  <= 1'b1;
            data_out <= '0;
            op_error <= 1'b0;
            for (int i = 0; i < LEN; i++) stub_mem[i] <= '0;
        end else if (op_en) begin
            if (stub_hang) begin
                op_done <= 1'b0;
            end else begin
                op_done <= 1'b1;
                case (op_sel)
                    3'd0: begin
                        data_out <= {{IW{1'b0}}, stub_mem[index_in[2:0]]};
                        op_error <= 1'b0;
                    end
                    3'd1: begin
                        stub_mem[index_in[2:0]] <= data_in;
                        data_out <= {index_in, data_in};
                        op_error <= 1'b0;
                    end
                    default: begin
                        data_out <= {index_in, data_in ^ 32'h5A5A5A5A};
                        op_error <= (op_sel == 3'd6);
                    end
                endcase
            end
        end
    end

    always @(posedge clk) begin
        ncyc <= ncyc + 1;
        if (op_en === 1'b1) begin
            op_en_cnt <= op_en_cnt + 1;
            last_gap  <= ncyc - last_en;
            last_en   <= ncyc;
        end
    end

    function automatic rsp_t model(input logic [2:0] op, input logic [DW-1:0] d, input logic [IW-1:0] idx);
        rsp_t r;
        r = '0;
        if (op == 3'd7 || (op <= 3'd1 && idx >= IW'(LEN))) begin
            r.err = 1'b1;
        end else if (stub_hang) begin
            r.err = 1'b1;
            r.tmo = 1'b1;
        end else if (op == 3'd0) begin
            r.data = {{IW{1'b0}}, ref_mem[idx[2:0]]};
        end else if (op == 3'd1) begin
            r.data = {idx, d};
        end else begin
            r.data = {idx, d ^ 32'h5A5A5A5A};
            r.err  = (op == 3'd6);
        end
        return r;
    endfunction

    // Called on a negedge; returns on the negedge of the cycle after acceptance.
    task automatic send_cmd(input logic [2:0] op, input logic [DW-1:0] d, input logic [IW-1:0] idx);
        int   n;
        rsp_t r;
        n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        cmd_index = idx;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept: cmd_ready is %b after %0d cycles, required 1", cmd_ready, n);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_data  = $urandom;
        cmd_index = IW'($urandom);
        r = model(op, d, idx);
        if (op == 3'd1 && !r.err) ref_mem[idx[2:0]] = d;
        exp_q.push_back(r);
    endtask

    task automatic get_rsp(input string name, output int lat);
        rsp_t e;
        int   n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        lat = n;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s rsp_valid: got %b after %0d cycles, required 1", name, rsp_valid, n);
        end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s rsp_unexpected: got a response, required none", name);
        end else begin
            e = exp_q.pop_front();
            if ({rsp_data, rsp_error, rsp_timeout} !== e) begin
                errors++;
                $display("FAIL %s rsp: got data %h err %b tmo %b, required data %h err %b tmo %b",
                         name, rsp_data, rsp_error, rsp_timeout, e.data, e.err, e.tmo);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic clear_model();
        exp_q.delete();
        for (int i = 0; i < LEN; i++) ref_mem[i] = '0;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_data  = '0;
        cmd_index = '0;
        rsp_ready = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        checks++;
        if ({cmd_ready, op_en, rsp_valid, rsp_error, rsp_timeout} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready/en/valid/err/tmo %b, required 00000",
                     {cmd_ready, op_en, rsp_valid, rsp_error, rsp_timeout});
        end
        checks++;
        if ({op_sel, data_in, index_in, rsp_data} !== '0) begin
            errors++;
            $display("FAIL reset_data: op_sel %h data_in %h index_in %h rsp_data %h, required all 0",
                     op_sel, data_in, index_in, rsp_data);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: cmd_ready %b, required 1", cmd_ready);
        end
    endtask

    task automatic test_write_read();
        int lat;
        int base;
        base = op_en_cnt;
        send_cmd(3'd1, 32'hDEADBEEF, 4'd3);
        checks++;
        if ({op_en, op_sel, data_in, index_in} !== {1'b1, 3'd1, 32'hDEADBEEF, 4'd3}) begin
            errors++;
            $display("FAIL write_issue: op_en %b op_sel %0d data_in %h index_in %0d, required 1 1 deadbeef 3",
                     op_en, op_sel, data_in, index_in);
        end
        get_rsp("write", lat);
        send_cmd(3'd1, 32'h0BADF00D, 4'd0);
        get_rsp("write0", lat);
        send_cmd(3'd0, $urandom, 4'd3);
        checks++;
        if ({op_en, op_sel, index_in} !== {1'b1, 3'd0, 4'd3}) begin
            errors++;
            $display("FAIL read_issue: op_en %b op_sel %0d index_in %0d, required 1 0 3", op_en, op_sel, index_in);
        end
        get_rsp("read", lat);
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL read_latency: rsp_valid %0d cycles after issue, required 2", lat);
        end
        checks++;
        if (op_en_cnt - base != 3) begin
            errors++;
            $display("FAIL op_en_pulses: counted %0d, required 3", op_en_cnt - base);
        end
    endtask

    task automatic test_range_error();
        int lat;
        int base;
        base = op_en_cnt;
        send_cmd(3'd0, $urandom, 4'd8);
        get_rsp("read_idx8", lat);
        checks++;
        if (lat != 0) begin
            errors++;
            $display("FAIL range_latency: rsp_valid %0d cycles after accept cycle, required 0", lat);
        end
        send_cmd(3'd1, $urandom, 4'd15);
        get_rsp("write_idx15", lat);
        checks++;
        if (op_en_cnt != base) begin
            errors++;
            $display("FAIL range_no_issue: op_en pulses %0d, required 0", op_en_cnt - base);
        end
    endtask

    task automatic test_bad_opcode();
        int lat;
        int base;
        base = op_en_cnt;
        send_cmd(3'd7, $urandom, 4'd0);
        get_rsp("opcode7", lat);
        checks++;
        if (op_en_cnt != base) begin
            errors++;
            $display("FAIL opcode7_no_issue: op_en pulses %0d, required 0", op_en_cnt - base);
        end
        send_cmd(3'd0, $urandom, 4'd0);
        get_rsp("read_after_bad", lat);
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL read_after_bad_latency: %0d, required 2", lat);
        end
    endtask

    task automatic test_other_ops();
        int lat;
        for (int op = 2; op <= 6; op++) begin
            send_cmd(3'(op), $urandom, IW'($urandom_range(0, LEN - 1)));
            get_rsp($sformatf("op%0d", op), lat);
        end
    endtask

    task automatic test_backpressure();
        int   lat;
        int   n;
        int   base;
        rsp_t e;
        send_cmd(3'd0, $urandom, 4'd3);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        e = (exp_q.size() != 0) ? exp_q[0] : '0;
        base      = op_en_cnt;
        cmd_valid = 1'b1;
        cmd_op    = 3'd1;
        cmd_data  = 32'h12345678;
        cmd_index = 4'd5;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({rsp_valid, cmd_ready} !== 2'b10 || {rsp_data, rsp_error, rsp_timeout} !== e) begin
                errors++;
                $display("FAIL stall_%0d: valid %b ready %b data %h, required 1 0 %h",
                         i, rsp_valid, cmd_ready, rsp_data, e.data);
            end
            @(negedge clk);
        end
        checks++;
        if (op_en_cnt != base) begin
            errors++;
            $display("FAIL stall_no_accept: op_en pulses %0d, required 0", op_en_cnt - base);
        end
        cmd_valid = 1'b0;
        get_rsp("bp_read", lat);
        send_cmd(3'd1, 32'h12345678, 4'd5);
        get_rsp("bp_write", lat);
        send_cmd(3'd0, $urandom, 4'd5);
        get_rsp("bp_readback", lat);
    endtask

    task automatic test_back_to_back();
        int lat;
        send_cmd(3'd1, 32'hA5A5_0001, 4'd1);
        get_rsp("b2b_w1", lat);
        send_cmd(3'd1, 32'hA5A5_0007, 4'd7);
        get_rsp("b2b_w7", lat);
        checks++;
        if (last_gap != 4) begin
            errors++;
            $display("FAIL b2b_gap1: op_en spacing %0d, required 4", last_gap);
        end
        send_cmd(3'd0, $urandom, 4'd1);
        get_rsp("b2b_r1", lat);
        checks++;
        if (last_gap != 4) begin
            errors++;
            $display("FAIL b2b_gap2: op_en spacing %0d, required 4", last_gap);
        end
    endtask

    task automatic test_reset_mid_op();
        int   lat;
        logic seen;
        stub_hang = 1'b1;
        send_cmd(3'd0, $urandom, 4'd3);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, op_en, cmd_ready} !== 3'b000) begin
            errors++;
            $display("FAIL midreset_outputs: valid %b op_en %b ready %b, required 000", rsp_valid, op_en, cmd_ready);
        end
        clear_model();
        stub_hang = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_ready: cmd_ready %b, required 1", cmd_ready);
        end
        seen = 1'b0;
        repeat (5) begin
            if (rsp_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midreset_stale: stale rsp_valid seen, required none");
        end
        send_cmd(3'd0, $urandom, 4'd3);
        get_rsp("read_after_reset", lat);
    endtask

    task automatic test_timeout();
        int lat;
`ifdef LIST_CMD_TIMEOUT_EN
        stub_hang = 1'b1;
        send_cmd(3'd0, $urandom, 4'd2);
        get_rsp("timeout", lat);
        checks++;
        if (lat != TMO + 1) begin
            errors++;
            $display("FAIL timeout_latency: %0d cycles after issue, required %0d", lat, TMO + 1);
        end
        stub_hang = 1'b0;
        send_cmd(3'd0, $urandom, 4'd1);
        get_rsp("read_after_timeout", lat);
`else
        logic seen;
        stub_hang = 1'b1;
        send_cmd(3'd0, $urandom, 4'd2);
        seen = 1'b0;
        repeat (100) begin
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL no_timeout: left WAIT within 100 cycles, required to stay");
        end
        rst = 1'b0;
        clear_model();
        stub_hang = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send_cmd(3'd0, $urandom, 4'd1);
        get_rsp("read_after_hang", lat);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_read();
        test_range_error();
        test_bad_opcode();
        test_other_ops();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        test_timeout();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d responses never arrived, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
